// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 Hz raster timing constants and derived sync
//               windows. The game core and test models share these constants.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int unsigned C_CNT_W    = 10;  // width of x/y raster counters
  localparam int unsigned C_DIV_W    = 6;   // width of the update divider

  localparam int unsigned C_H_VIS    = 640;
  localparam int unsigned C_H_FP     = 16;
  localparam int unsigned C_H_SYNC   = 96;
  localparam int unsigned C_H_BP     = 48;
  localparam int unsigned C_H_TOTAL  = C_H_VIS + C_H_FP + C_H_SYNC + C_H_BP;

  localparam int unsigned C_V_VIS    = 480;
  localparam int unsigned C_V_FP     = 10;
  localparam int unsigned C_V_SYNC   = 2;
  localparam int unsigned C_V_BP     = 33;
  localparam int unsigned C_V_TOTAL  = C_V_VIS + C_V_FP + C_V_SYNC + C_V_BP;

  // Active level of hsync/vsync (0 = active-low)
  localparam logic        C_SYNC_POL = 1'b0;

  // First count inside the sync pulse: right after the front porch
  function automatic int unsigned sync_first(input int unsigned vis,
                                             input int unsigned fp);
    return vis + fp;
  endfunction

  // Last count inside the sync pulse (inclusive)
  function automatic int unsigned sync_last(input int unsigned vis,
                                            input int unsigned fp,
                                            input int unsigned sync);
    return vis + fp + sync - 1;
  endfunction

  localparam int unsigned C_H_SYNC_FIRST = sync_first(C_H_VIS, C_H_FP);
  localparam int unsigned C_H_SYNC_LAST  = sync_last(C_H_VIS, C_H_FP, C_H_SYNC);
  localparam int unsigned C_V_SYNC_FIRST = sync_first(C_V_VIS, C_V_FP);
  localparam int unsigned C_V_SYNC_LAST  = sync_last(C_V_VIS, C_V_FP, C_V_SYNC);

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis (horizontal or vertical). Wrapping counter
//               with enable, terminal-count flag, and visible/sync decodes
//               registered from the pre-edge count so they line up with
//               externally registered copies of the count.
// Ports       : i_clk      - pixel clock
//               i_rst_n    - asynchronous active-low reset
//               i_en       - advance the counter this cycle
//               o_count    - current (pre-edge) count, 0..TOTAL-1
//               o_tc       - count is TOTAL-1 and i_en is high (wraps now)
//               o_vis      - registered: previous count was < VIS
//               o_sync     - registered: previous count in sync window,
//                            driven at SYNC_POL when active
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned VIS        = 640,
  parameter int unsigned SYNC_FIRST = 656,
  parameter int unsigned SYNC_LAST  = 751,
  parameter logic        SYNC_POL   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc,
  output logic             o_vis,
  output logic             o_sync
);

  localparam logic [CNT_W-1:0] C_LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] C_VIS        = CNT_W'(VIS);
  localparam logic [CNT_W-1:0] C_SYNC_FIRST = CNT_W'(SYNC_FIRST);
  localparam logic [CNT_W-1:0] C_SYNC_LAST  = CNT_W'(SYNC_LAST);
  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic             r_vis;
  logic             r_sync;
  logic             w_at_last;
  logic             w_vis;
  logic             w_sync_win;

  assign w_at_last  = (r_count == C_LAST);
  assign w_vis      = (r_count < C_VIS);
  assign w_sync_win = (r_count >= C_SYNC_FIRST) && (r_count <= C_SYNC_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_vis   <= 1'b0;
      r_sync  <= ~SYNC_POL;
    end else begin
      if (i_en) begin
        r_count <= w_at_last ? '0 : (r_count + C_ONE);
      end
      // Decodes sample every cycle, independent of i_en, so the vertical
      // decode stays aligned with the registered y output across a line.
      r_vis  <= w_vis;
      r_sync <= w_sync_win ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign o_count = r_count;
  assign o_tc    = i_en & w_at_last;
  assign o_vis   = r_vis;
  assign o_sync  = r_sync;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing source. Two axis counters produce the
//               raster. Every output is registered from the pre-edge counter
//               values, so outputs are coherent and lag the counters by one
//               cycle. Also generates a frame-divided game-update strobe at
//               the start of vertical blank.
// Ports       : i_pixel_clk   - pixel clock (25 MHz for 640x480@60)
//               i_rst_n       - asynchronous active-low reset
//               i_update_div  - update period minus one, in frames
//               o_x_count     - pixel column, 0..H_TOTAL-1
//               o_y_count     - line, 0..V_TOTAL-1
//               o_display     - x < H_VIS and y < V_VIS
//               o_hsync       - horizontal sync (active level SYNC_POL)
//               o_vsync       - vertical sync (active level SYNC_POL)
//               o_frame_start - one-cycle pulse while outputs show (0,0)
//               o_update      - one-cycle pulse while outputs show (0,V_VIS)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS    = C_H_VIS,
  parameter int unsigned H_FP     = C_H_FP,
  parameter int unsigned H_SYNC   = C_H_SYNC,
  parameter int unsigned H_BP     = C_H_BP,
  parameter int unsigned V_VIS    = C_V_VIS,
  parameter int unsigned V_FP     = C_V_FP,
  parameter int unsigned V_SYNC   = C_V_SYNC,
  parameter int unsigned V_BP     = C_V_BP,
  parameter logic        SYNC_POL = C_SYNC_POL
) (
  input  logic               i_pixel_clk,
  input  logic               i_rst_n,
  input  logic [C_DIV_W-1:0] i_update_div,
  output logic [C_CNT_W-1:0] o_x_count,
  output logic [C_CNT_W-1:0] o_y_count,
  output logic               o_display,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_frame_start,
  output logic               o_update
);

  localparam int unsigned      C_LINE_LEN    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned      C_FRAME_LINES = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [C_CNT_W-1:0] C_V_BLANK   = C_CNT_W'(V_VIS);
  localparam logic [C_DIV_W-1:0] C_FC_ONE    = C_DIV_W'(1);

  logic [C_CNT_W-1:0] w_h_cnt;
  logic [C_CNT_W-1:0] w_v_cnt;
  logic               w_h_tc;
  logic               w_v_tc;
  logic               w_h_vis;
  logic               w_v_vis;
  logic               w_hsync;
  logic               w_vsync;
  logic               w_vblank_start;
  logic               w_div_hit;

  logic [C_CNT_W-1:0] r_x_count;
  logic [C_CNT_W-1:0] r_y_count;
  logic               r_frame_start;
  logic               r_update;
  logic               r_at_origin;
  logic [C_DIV_W-1:0] r_div_lat;
  logic [C_DIV_W-1:0] r_frame_cnt;

  vga_axis_counter #(
    .CNT_W      (C_CNT_W),
    .TOTAL      (C_LINE_LEN),
    .VIS        (H_VIS),
    .SYNC_FIRST (sync_first(H_VIS, H_FP)),
    .SYNC_LAST  (sync_last(H_VIS, H_FP, H_SYNC)),
    .SYNC_POL   (SYNC_POL)
  ) u_h_axis (
    .i_clk   (i_pixel_clk),
    .i_rst_n (i_rst_n),
    .i_en    (1'b1),
    .o_count (w_h_cnt),
    .o_tc    (w_h_tc),
    .o_vis   (w_h_vis),
    .o_sync  (w_hsync)
  );

  vga_axis_counter #(
    .CNT_W      (C_CNT_W),
    .TOTAL      (C_FRAME_LINES),
    .VIS        (V_VIS),
    .SYNC_FIRST (sync_first(V_VIS, V_FP)),
    .SYNC_LAST  (sync_last(V_VIS, V_FP, V_SYNC)),
    .SYNC_POL   (SYNC_POL)
  ) u_v_axis (
    .i_clk   (i_pixel_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_h_tc),
    .o_count (w_v_cnt),
    .o_tc    (w_v_tc),
    .o_vis   (w_v_vis),
    .o_sync  (w_vsync)
  );

  // Counters sit at the first pixel of the bottom blanking region
  assign w_vblank_start = (w_h_cnt == '0) && (w_v_cnt == C_V_BLANK);

  // >= rather than == so that a divider lowered below the running count
  // still fires at the next vblank instead of waiting for a 6-bit wrap.
  assign w_div_hit = (r_frame_cnt >= r_div_lat);

  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x_count     <= '0;
      r_y_count     <= '0;
      r_frame_start <= 1'b0;
      r_update      <= 1'b0;
      // Counters reset to (0,0), so the origin flag starts set
      r_at_origin   <= 1'b1;
      // Overwritten by i_update_div on the first edge after release
      r_div_lat     <= '0;
      r_frame_cnt   <= '0;
    end else begin
      r_x_count     <= w_h_cnt;
      r_y_count     <= w_v_cnt;
      // Both axes wrap together exactly when the counters next show (0,0)
      r_at_origin   <= w_h_tc & w_v_tc;
      r_frame_start <= r_at_origin;
      if (r_at_origin) begin
        r_div_lat <= i_update_div;
      end
      r_update <= w_vblank_start & w_div_hit;
      if (w_vblank_start) begin
        r_frame_cnt <= w_div_hit ? '0 : (r_frame_cnt + C_FC_ONE);
      end
    end
  end

  assign o_x_count     = r_x_count;
  assign o_y_count     = r_y_count;
  assign o_display     = w_h_vis & w_v_vis;
  assign o_hsync       = w_hsync;
  assign o_vsync       = w_vsync;
  assign o_frame_start = r_frame_start;
  assign o_update      = r_update;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen using a reduced raster
//               (25x15) so several frames fit in a short run. A reference
//               model in output coordinates pushes the expected output vector
//               on every clock edge; a checker pops and compares on the
//               falling edge. Interval checks on update/frame_start and sync
//               widths plus asynchronous reset checks complete the set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int HT = HV + HF + HS + HB;  // 25
  localparam int VV = 8, VF = 2, VS = 2, VB = 3;
  localparam int VT = VV + VF + VS + VB;  // 15
  localparam int FRAME = HT * VT;         // 375

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic [5:0] update_div = '0;
  logic [9:0] o_x_count;
  logic [9:0] o_y_count;
  logic       o_display, o_hsync, o_vsync, o_frame_start, o_update;

  always #20 clk = ~clk;

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .i_pixel_clk   (clk),
    .i_rst_n       (rst_n),
    .i_update_div  (update_div),
    .o_x_count     (o_x_count),
    .o_y_count     (o_y_count),
    .o_display     (o_display),
    .o_hsync       (o_hsync),
    .o_vsync       (o_vsync),
    .o_frame_start (o_frame_start),
    .o_update      (o_update)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       disp;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       upd;
  } vec_t;

  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   run_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Reference model: tracks the position the outputs should show
  int m_x, m_y, m_fc, m_div;
  bit m_first = 1'b1;

  always @(posedge clk) begin
    vec_t e;
    if (!rst_n || !run_en) begin
      m_first = 1'b1;
      m_fc    = 0;
      m_div   = 0;
    end else begin
      if (m_first) begin
        m_x = 0;
        m_y = 0;
        m_first = 1'b0;
      end else begin
        m_x++;
        if (m_x == HT) begin
          m_x = 0;
          m_y++;
          if (m_y == VT) m_y = 0;
        end
      end
      e.x    = 10'(m_x);
      e.y    = 10'(m_y);
      e.disp = (m_x < HV) && (m_y < VV);
      e.hs   = !((m_x >= HV + HF) && (m_x < HV + HF + HS));
      e.vs   = !((m_y >= VV + VF) && (m_y < VV + VF + VS));
      e.fs   = (m_x == 0) && (m_y == 0);
      if (e.fs) m_div = int'(update_div);
      e.upd  = 1'b0;
      if (m_x == 0 && m_y == VV) begin
        if (m_fc >= m_div) begin
          e.upd = 1'b1;
          m_fc  = 0;
        end else begin
          m_fc++;
        end
      end
      sb.push_back(e);
    end
  end

  // Checker: one popped vector per cycle, plus event timestamps
  int cyc = 0;
  int upd_t[$];
  int fs_t[$];
  int hs_low = 0;
  int vs_low = 0;

  always @(negedge clk) begin
    vec_t e;
    vec_t a;
    if (!rst_n) begin
      sb.delete();
      upd_t.delete();
      fs_t.delete();
      cyc    = 0;
      hs_low = 0;
      vs_low = 0;
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {o_x_count, o_y_count, o_display, o_hsync, o_vsync, o_frame_start, o_update};
      cyc++;
      check("raster", 32'(a), 32'(e));
      if (o_update) begin
        upd_t.push_back(cyc);
        check("upd_in_blank", 32'(o_display), 32'd0);
      end
      if (o_frame_start) fs_t.push_back(cyc);
      if (cyc <= FRAME) begin
        if (!o_hsync) hs_low++;
        if (!o_vsync) vs_low++;
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Asserts reset between edges and checks outputs before any clock edge,
  // then holds reset across edges and releases just after a falling edge.
  task automatic do_reset(input logic [5:0] div);
    @(negedge clk);
    #3;
    rst_n      = 1'b0;
    update_div = div;
    run_en     = 1'b1;
    #1;
    check("rst_x",      32'(o_x_count),     32'd0);
    check("rst_y",      32'(o_y_count),     32'd0);
    check("rst_disp",   32'(o_display),     32'd0);
    check("rst_hsync",  32'(o_hsync),       32'd1);
    check("rst_vsync",  32'(o_vsync),       32'd1);
    check("rst_fstart", 32'(o_frame_start), 32'd0);
    check("rst_update", 32'(o_update),      32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_x", 32'(o_x_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Divider 0: update every frame, raster timing and sync widths
    do_reset(6'd0);
    run(2 * FRAME + VV * HT + 10);
    check("a_first_upd",  32'(qat(upd_t, 0)), 32'(VV * HT + 1));
    check("a_upd_period", 32'(qat(upd_t, 1) - qat(upd_t, 0)), 32'(FRAME));
    check("a_fs_first",   32'(qat(fs_t, 0)), 32'd1);
    check("a_fs_period",  32'(qat(fs_t, 1) - qat(fs_t, 0)), 32'(FRAME));
    check("a_hs_low",     32'(hs_low), 32'(HS * VT));
    check("a_vs_low",     32'(vs_low), 32'(VS * HT));

    // Divider 3: one update every four frames
    do_reset(6'd3);
    run(VV * HT + 8 * FRAME + 10);
    check("b_first_upd",  32'(qat(upd_t, 0)), 32'(VV * HT + 1 + 3 * FRAME));
    check("b_upd_period", 32'(qat(upd_t, 1) - qat(upd_t, 0)), 32'(4 * FRAME));

    // Divider lowered 3->0 mid-frame: takes effect only from the next frame
    // start, then fires (>= path) at that frame's vblank and clears
    do_reset(6'd3);
    run(FRAME + 2 * HT + 5);
    update_div = 6'd0;
    run(1000);
    check("c_first_upd", 32'(qat(upd_t, 0)), 32'(VV * HT + 1 + 2 * FRAME));
    check("c_next_upd",  32'(qat(upd_t, 1)), 32'(VV * HT + 1 + 3 * FRAME));

    // Reset mid-frame: asynchronous reset values, then clean restart
    do_reset(6'd0);
    run(5 * HT + 7);
    do_reset(6'd0);
    run(VV * HT + 20);
    check("d_fs_first",  32'(qat(fs_t, 0)), 32'd1);
    check("d_first_upd", 32'(qat(upd_t, 0)), 32'(VV * HT + 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
